test_core: RTL



---
 rtl/test_core.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/test_core.sv
// test_core: stub crypto core for the root-of-trust core slot.
// Holds a DEPTH-word register bank, runs a LATENCY-cycle rotate-XOR digest
// on START with a busy/done handshake, and answers unmapped reads with ID_WORD.
// Optional feature macro: TEST_CORE_START_CNT_EN adds a 32-bit completed-START
// counter readable at address DEPTH+1 (otherwise that address reads ID_WORD).
module test_core #(
    parameter int                DATA_W  = 64,
    parameter int                DEPTH   = 8,
    parameter int                LATENCY = 16,
    parameter logic [DATA_W-1:0] ID_WORD = {DATA_W{1'b1}}
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data_in,
    input  logic [63:0]       i_add,
    input  logic [31:0]       i_control,
    output logic [DATA_W-1:0] o_data_out,
    output logic              o_end_op
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(LATENCY + 1);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_CLR   = 3'b001;
    localparam logic [2:0] OP_LOAD  = 3'b010;
    localparam logic [2:0] OP_READ  = 3'b011;
    localparam logic [2:0] OP_START = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   bank_q [DEPTH];
    logic [DATA_W-1:0]   acc_q;
    logic [DATA_W-1:0]   acc_d;
    logic [DATA_W-1:0]   result_q;
    logic [DATA_W-1:0]   data_out_q;
    logic [DATA_W-1:0]   rd_data_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                end_op_q;

    logic [2:0]          op;
    logic                in_bank;
    logic [ADDR_W-1:0]   bank_idx;
    logic [ADDR_W-1:0]   cnt_idx;
    logic [CNT_W+ADDR_W-1:0] cnt_wide;
    logic                last_step;
    logic                unused_ctrl;

    // Rotate left by one over the full data width.
    function automatic logic [DATA_W-1:0] rotl1(input logic [DATA_W-1:0] v);
        return {v[DATA_W-2:0], v[DATA_W-1]};
    endfunction

    assign op          = i_control[2:0];
    assign unused_ctrl = ^i_control[31:3];

    // Any nonzero upper address bit makes the compare fail, so out-of-range
    // addresses never alias into the bank.
    assign in_bank   = (i_add < 64'(DEPTH));
    assign bank_idx  = i_add[ADDR_W-1:0];

    // cnt may be narrower or wider than the bank index; widen before taking mod DEPTH.
    assign cnt_wide  = {{ADDR_W{1'b0}}, cnt_q};
    assign cnt_idx   = cnt_wide[ADDR_W-1:0];
    assign last_step = (cnt_q == CNT_W'(LATENCY - 1));
    assign acc_d     = rotl1(acc_q) ^ bank_q[cnt_idx];

`ifdef TEST_CORE_START_CNT_EN
    logic [31:0]       start_cnt_q;
    logic [DATA_W-1:0] start_cnt_rd;

    assign start_cnt_rd = DATA_W'(start_cnt_q);

    // Completed-START counter: survives CLR, cleared only by async reset.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            start_cnt_q <= '0;
        end else if (state_q == S_BUSY && last_step && op != OP_CLR) begin
            start_cnt_q <= start_cnt_q + 32'd1;
        end
    end
`endif

    // Read-address decode for the slot read port.
    always_comb begin
        rd_data_d = ID_WORD;
        if (in_bank) begin
            rd_data_d = bank_q[bank_idx];
        end else if (i_add == 64'(DEPTH)) begin
            rd_data_d = result_q;
        end
`ifdef TEST_CORE_START_CNT_EN
        else if (i_add == 64'(DEPTH) + 64'd1) begin
            rd_data_d = start_cnt_rd;
        end
`endif
    end

    // Control FSM with register bank, digest datapath and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            data_out_q <= ID_WORD;
            end_op_q   <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= '0;
            end
        end else if (op == OP_CLR) begin
            // Soft clear wins in every state, including mid-digest.
            state_q    <= S_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            data_out_q <= ID_WORD;
            end_op_q   <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    case (op)
                        OP_LOAD: begin
                            if (in_bank) begin
                                bank_q[bank_idx] <= i_data_in;
                            end
                        end
                        OP_READ: begin
                            data_out_q <= rd_data_d;
                        end
                        OP_START: begin
                            acc_q    <= '0;
                            cnt_q    <= '0;
                            state_q  <= S_BUSY;
                            end_op_q <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                S_BUSY: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_step) begin
                        result_q <= acc_d;
                        state_q  <= S_DONE;
                        end_op_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    // Holding START parks here so the host cannot relaunch by accident.
                    if (op != OP_START) begin
                        state_q <= S_IDLE;
                        if (op == OP_LOAD && in_bank) begin
                            bank_q[bank_idx] <= i_data_in;
                        end
                        if (op == OP_READ) begin
                            data_out_q <= rd_data_d;
                        end
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    end_op_q <= 1'b1;
                end
            endcase
        end
    end

    assign o_data_out = data_out_q;
    assign o_end_op   = end_op_q;

endmodule
